// File: rtl/cfe_wfb_pkg.sv
// CFE wait-feedback shared types.
// Channel FSM states, step direction and per-channel record.
package cfe_wfb_pkg;

   localparam int WFB_NBW_HOLD = 4;

   typedef enum logic [1:0] {
      WFB_START = 2'd0,
      WFB_TRACK = 2'd1,
      WFB_HOLD  = 2'd2
   } wfb_state_e;

   typedef enum logic {
      WFB_DIR_DEC = 1'b0,
      WFB_DIR_INC = 1'b1
   } wfb_dir_e;

   typedef struct packed {
      wfb_state_e                state;
      logic [WFB_NBW_HOLD-1:0]   hold;
   } wfb_chan_t;

endpackage

// File: rtl/cfe_wfb_sat_step.sv
// CFE wait-feedback saturating step.
// w +/- step, wrap goes to the clamp, then clamp to max and to min.
module cfe_wfb_sat_step
   import cfe_wfb_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] i_wait,
   input  logic [W-1:0] i_step,
   input  logic [W-1:0] i_min,
   input  logic [W-1:0] i_max,
   input  wfb_dir_e     i_dir,
   output logic [W-1:0] o_wait
);

   logic [W:0]   full;
   logic [W-1:0] raw;
   logic [W-1:0] clmp;

   // step in W+1 bits; max clamp first so min wins when min > max
   always_comb begin
      full = '0;
      raw  = i_wait;
      unique case (i_dir)
         WFB_DIR_DEC: begin
            full = {1'b0, i_wait} - {1'b0, i_step};
            raw  = full[W] ? i_min : full[W-1:0];
         end
         WFB_DIR_INC: begin
            full = {1'b0, i_wait} + {1'b0, i_step};
            raw  = full[W] ? i_max : full[W-1:0];
         end
         default: raw = i_wait;
      endcase
      clmp   = (raw > i_max) ? i_max : raw;
      o_wait = (clmp < i_min) ? i_min : clmp;
   end

endmodule

// File: rtl/cfe_wait_feedback_mc.sv
// Multi-channel CFE feedback-wait controller (2-stage pipe).
// CFE_WFB_STATS_EN adds per-channel saturating decrease counters.
module cfe_wait_feedback_mc
   import cfe_wfb_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int CFE_NBW_FO   = 13,
   parameter int CFE_NBW_LAT  = 32,
   parameter int CFE_NBW_CH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CFE_NBW_HOLD = WFB_NBW_HOLD
) (
   input  logic                          clk,
   input  logic                          rst_async_n,
   input  logic                          i_valid,
   input  logic [CFE_NBW_CH-1:0]         i_ch,
   input  logic [CFE_NBW_FO-1:0]         i_fo_value,
   input  logic                          i_clear,
   input  logic                          i_enable,
   input  logic [CFE_NBW_FO-1:0]         i_dec_thr,
   input  logic [CFE_NBW_FO-1:0]         i_inc_thr,
   input  logic [CFE_NBW_LAT-1:0]        i_dec_step,
   input  logic [CFE_NBW_LAT-1:0]        i_inc_step,
   input  logic [CFE_NBW_LAT-1:0]        i_default_wait,
   input  logic [CFE_NBW_LAT-1:0]        i_min_wait,
   input  logic [CFE_NBW_LAT-1:0]        i_max_wait,
   input  logic [CFE_NBW_HOLD-1:0]       i_hold_len,
   output logic [NUM_CH*CFE_NBW_LAT-1:0] o_wait,
   output logic                          o_upd_valid,
`ifdef CFE_WFB_STATS_EN
   output logic [NUM_CH*16-1:0]          o_dec_cnt,
`endif
   output logic [CFE_NBW_CH-1:0]         o_upd_ch
);

   localparam int DW = CFE_NBW_FO + 1;
   localparam logic [CFE_NBW_CH:0] CH_LIM = NUM_CH[CFE_NBW_CH:0];

   logic                   s1_vld_q, s1_vld_d;
   logic [CFE_NBW_CH-1:0]  s1_ch_q, s1_ch_d;
   logic [DW-1:0]          s1_delta_q, s1_delta_d;
   logic [CFE_NBW_FO-1:0]  last_fo_q [NUM_CH];
   logic [CFE_NBW_FO-1:0]  last_fo_d [NUM_CH];
   logic [CFE_NBW_LAT-1:0] wait_q [NUM_CH];
   logic [CFE_NBW_LAT-1:0] wait_d [NUM_CH];
   wfb_chan_t              chan_q [NUM_CH];
   wfb_chan_t              chan_d [NUM_CH];
   logic                   init_q, init_d;
   logic                   upd_valid_q, upd_valid_d;
   logic [CFE_NBW_CH-1:0]  upd_ch_q, upd_ch_d;

   logic                   accept;
   logic [CFE_NBW_FO-1:0]  lf;
   logic [DW-1:0]          diff;
   logic [DW-1:0]          delta_abs;
   wfb_chan_t              cur, nxt;
   logic [CFE_NBW_LAT-1:0] cur_wait, nxt_wait, step_wait, step;
   logic                   is_dec, is_inc, dec_evt;
   wfb_dir_e               step_dir;

   assign accept   = i_valid && ({1'b0, i_ch} < CH_LIM) && !i_clear;
   assign lf       = last_fo_q[i_ch];
   assign cur      = chan_q[s1_ch_q];
   assign cur_wait = wait_q[s1_ch_q];
   assign is_dec   = s1_delta_q > {1'b0, i_dec_thr};
   assign is_inc   = s1_delta_q < {1'b0, i_inc_thr};
   assign step_dir = is_dec ? WFB_DIR_DEC : WFB_DIR_INC;
   assign step     = is_dec ? i_dec_step : i_inc_step;

   cfe_wfb_sat_step #(
      .W      (CFE_NBW_LAT)
   ) u_step (
      .i_wait (cur_wait),
      .i_step (step),
      .i_min  (i_min_wait),
      .i_max  (i_max_wait),
      .i_dir  (step_dir),
      .o_wait (step_wait)
   );

   // S1: |delta| against stored estimate, store new estimate
   always_comb begin
      s1_vld_d   = 1'b0;
      s1_ch_d    = s1_ch_q;
      s1_delta_d = s1_delta_q;
      last_fo_d  = last_fo_q;
      diff       = {i_fo_value[CFE_NBW_FO-1], i_fo_value}
                 - {lf[CFE_NBW_FO-1], lf};
      delta_abs  = diff[DW-1] ? (~diff + 1'b1) : diff;
      if (accept) begin
         s1_vld_d          = 1'b1;
         s1_ch_d           = i_ch;
         s1_delta_d        = delta_abs;
         last_fo_d[i_ch]   = i_fo_value;
      end
      if (i_clear) begin
         for (int c = 0; c < NUM_CH; c++) last_fo_d[c] = '0;
      end
   end

   // S2: per-channel FSM, read-modify-write of live state
   always_comb begin
      wait_d      = wait_q;
      chan_d      = chan_q;
      init_d      = 1'b1;
      upd_valid_d = 1'b0;
      upd_ch_d    = upd_ch_q;
      nxt         = cur;
      nxt_wait    = cur_wait;
      dec_evt     = 1'b0;
      unique case (cur.state)
         WFB_START: nxt.state = WFB_TRACK;
         WFB_TRACK: begin
            if (is_dec) begin
               nxt_wait = step_wait;
               dec_evt  = 1'b1;
               if (i_hold_len != '0) begin
                  nxt.state = WFB_HOLD;
                  nxt.hold  = i_hold_len;
               end
            end else if (is_inc) begin
               nxt_wait = step_wait;
            end
         end
         WFB_HOLD: begin
            if (is_dec) begin
               nxt_wait = step_wait;
               dec_evt  = 1'b1;
               nxt.hold = i_hold_len;
               if (i_hold_len == '0) nxt.state = WFB_TRACK;
            end else if (is_inc) begin
               if (cur.hold[CFE_NBW_HOLD-1:1] == '0) begin
                  nxt.state = WFB_TRACK;
                  nxt.hold  = '0;
               end else begin
                  nxt.hold  = cur.hold - 1'b1;
               end
            end
         end
         default: nxt.state = WFB_START;
      endcase
      if (!init_q) begin
         for (int c = 0; c < NUM_CH; c++) wait_d[c] = i_default_wait;
      end
      if (s1_vld_q) begin
         wait_d[s1_ch_q] = nxt_wait;
         chan_d[s1_ch_q] = nxt;
         upd_valid_d     = 1'b1;
         upd_ch_d        = s1_ch_q;
      end
      if (i_clear) begin
         upd_valid_d = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            wait_d[c] = i_default_wait;
            chan_d[c] = '{state: WFB_START, hold: '0};
         end
      end
   end

   // pipeline and per-channel state registers
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         s1_vld_q    <= 1'b0;
         s1_ch_q     <= '0;
         s1_delta_q  <= '0;
         init_q      <= 1'b0;
         upd_valid_q <= 1'b0;
         upd_ch_q    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            last_fo_q[c] <= '0;
            wait_q[c]    <= '0;
            chan_q[c]    <= '{state: WFB_START, hold: '0};
         end
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_ch_q     <= s1_ch_d;
         s1_delta_q  <= s1_delta_d;
         init_q      <= init_d;
         upd_valid_q <= upd_valid_d;
         upd_ch_q    <= upd_ch_d;
         last_fo_q   <= last_fo_d;
         wait_q      <= wait_d;
         chan_q      <= chan_d;
      end
   end

   // before the first edge the register copy is not loaded yet
   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign o_wait[g*CFE_NBW_LAT +: CFE_NBW_LAT] =
         (!i_enable || !init_q) ? i_default_wait : wait_q[g];
   end

   assign o_upd_valid = upd_valid_q;
   assign o_upd_ch    = upd_ch_q;

`ifdef CFE_WFB_STATS_EN
   logic [15:0] dec_cnt_q [NUM_CH];
   logic [15:0] dec_cnt_d [NUM_CH];

   // saturating count of decrease events per channel
   always_comb begin
      dec_cnt_d = dec_cnt_q;
      if (s1_vld_q && dec_evt && (dec_cnt_q[s1_ch_q] != 16'hFFFF))
         dec_cnt_d[s1_ch_q] = dec_cnt_q[s1_ch_q] + 16'd1;
      if (i_clear) begin
         for (int c = 0; c < NUM_CH; c++) dec_cnt_d[c] = '0;
      end
   end

   // decrease counter registers
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         for (int c = 0; c < NUM_CH; c++) dec_cnt_q[c] <= '0;
      end else begin
         dec_cnt_q <= dec_cnt_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign o_dec_cnt[g*16 +: 16] = dec_cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_cfe_wait_feedback_mc.sv
// Directed bench for cfe_wait_feedback_mc.
// Hand-computed waits for ramp, hold, wrap, clear, enable, clamps.
module tb_cfe_wait_feedback_mc;

   localparam int NCH = 4;
   localparam int FO  = 13;
   localparam int LAT = 32;
   localparam int CHW = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               i_valid;
   logic [CHW-1:0]     i_ch;
   logic [FO-1:0]      i_fo_value;
   logic               i_clear;
   logic               i_enable;
   logic [FO-1:0]      i_dec_thr;
   logic [FO-1:0]      i_inc_thr;
   logic [LAT-1:0]     i_dec_step;
   logic [LAT-1:0]     i_inc_step;
   logic [LAT-1:0]     i_default_wait;
   logic [LAT-1:0]     i_min_wait;
   logic [LAT-1:0]     i_max_wait;
   logic [3:0]         i_hold_len;
   logic [NCH*LAT-1:0] o_wait;
   logic               o_upd_valid;
   logic [CHW-1:0]     o_upd_ch;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cfe_wait_feedback_mc #(
      .NUM_CH      (NCH),
      .CFE_NBW_FO  (FO),
      .CFE_NBW_LAT (LAT),
      .CFE_NBW_CH  (CHW)
   ) dut (
      .clk            (clk),
      .rst_async_n    (rst_n),
      .i_valid        (i_valid),
      .i_ch           (i_ch),
      .i_fo_value     (i_fo_value),
      .i_clear        (i_clear),
      .i_enable       (i_enable),
      .i_dec_thr      (i_dec_thr),
      .i_inc_thr      (i_inc_thr),
      .i_dec_step     (i_dec_step),
      .i_inc_step     (i_inc_step),
      .i_default_wait (i_default_wait),
      .i_min_wait     (i_min_wait),
      .i_max_wait     (i_max_wait),
      .i_hold_len     (i_hold_len),
      .o_wait         (o_wait),
      .o_upd_valid    (o_upd_valid),
      .o_upd_ch       (o_upd_ch)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] w(input int c);
      return o_wait[c*LAT +: LAT];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int c, input logic [FO-1:0] fo);
      i_valid    = 1'b1;
      i_ch       = c[CHW-1:0];
      i_fo_value = fo;
      tick();
      i_valid    = 1'b0;
   endtask

   task automatic put_s2(input int c, input logic [FO-1:0] fo);
      put(c, fo);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp;
      rst_n          = 1'b0;
      i_valid        = 1'b0;
      i_ch           = '0;
      i_fo_value     = '0;
      i_clear        = 1'b0;
      i_enable       = 1'b1;
      i_dec_thr      = 13'h200;
      i_inc_thr      = 13'h050;
      i_dec_step     = 32'h100;
      i_inc_step     = 32'h100;
      i_default_wait = 32'h100;
      i_min_wait     = 32'h100;
      i_max_wait     = 32'h1000;
      i_hold_len     = 4'd2;
      #1;
      chk("rst_upd_valid", {31'd0, o_upd_valid}, 32'd0);
      chk("rst_upd_ch", {30'd0, o_upd_ch}, 32'd0);
      for (int c = 0; c < NCH; c++)
         chk($sformatf("rst_w%0d", c), w(c), 32'h100);
      #11 rst_n = 1'b1;
      tick();

      // 1: first sample only leaves START
      put(0, 13'h010);
      chk("t1_upd_early", {31'd0, o_upd_valid}, 32'd0);
      tick();
      chk("t1_upd_valid", {31'd0, o_upd_valid}, 32'd1);
      chk("t1_upd_ch", {30'd0, o_upd_ch}, 32'd0);
      chk("t1_w0", w(0), 32'h100);
      tick();
      chk("t1_upd_pulse", {31'd0, o_upd_valid}, 32'd0);

      // 2: stable ramp on ch1 up to max
      put_s2(1, 13'h010);
      chk("t2_start", w(1), 32'h100);
      exp = 32'h100;
      for (int i = 1; i <= 16; i++) begin
         put_s2(1, (i % 2 == 1) ? 13'h020 : 13'h010);
         exp = (exp + 32'h100 > 32'h1000) ? 32'h1000 : exp + 32'h100;
         chk($sformatf("t2_w1_%0d", i), w(1), exp);
      end
      chk("t2_w0", w(0), 32'h100);
      chk("t2_w2", w(2), 32'h100);
      chk("t2_w3", w(3), 32'h100);

      // 3: back-to-back ramp on ch2, jump, hold, resume
      for (int k = 0; k < 8; k++) begin
         i_valid    = 1'b1;
         i_ch       = 2'd2;
         i_fo_value = 13'h010;
         tick();
      end
      i_valid = 1'b0;
      tick();
      chk("t3_ramp", w(2), 32'h800);
      chk("t3_upd_ch", {30'd0, o_upd_ch}, 32'd2);
      put_s2(2, 13'h400);
      chk("t3_jump", w(2), 32'h700);
      put_s2(2, 13'h410);
      chk("t3_hold1", w(2), 32'h700);
      put_s2(2, 13'h400);
      chk("t3_hold0", w(2), 32'h700);
      put_s2(2, 13'h410);
      chk("t3_resume", w(2), 32'h800);

      // 4: signed wrap gives full-scale delta; min clamp
      put_s2(1, 13'h0FFF);
      chk("t4_dec1", w(1), 32'hF00);
      put_s2(1, 13'h1000);
      chk("t4_wrap", w(1), 32'hE00);
      put_s2(0, 13'h0FFF);
      chk("t4_minclamp", w(0), 32'h100);

      // 5: clear while ch3 samples are in flight
      put_s2(3, 13'h010);
      i_valid    = 1'b1;
      i_ch       = 2'd3;
      i_fo_value = 13'h600;
      tick();
      i_fo_value = 13'h010;
      i_clear    = 1'b1;
      tick();
      i_clear    = 1'b0;
      i_valid    = 1'b0;
      chk("t5_flush0", {31'd0, o_upd_valid}, 32'd0);
      tick();
      chk("t5_flush1", {31'd0, o_upd_valid}, 32'd0);
      for (int c = 0; c < NCH; c++)
         chk($sformatf("t5_w%0d", c), w(c), 32'h100);
      put_s2(1, 13'h010);
      chk("t5_start", w(1), 32'h100);
      put_s2(1, 13'h010);
      chk("t5_track", w(1), 32'h200);

      // 6: enable override, then inverted clamps
      i_enable       = 1'b0;
      i_default_wait = 32'h300;
      #1;
      for (int c = 0; c < NCH; c++)
         chk($sformatf("t6_dis_w%0d", c), w(c), 32'h300);
      i_enable       = 1'b1;
      i_default_wait = 32'h100;
      #1;
      chk("t6_en_w1", w(1), 32'h200);
      i_min_wait = 32'h200;
      i_max_wait = 32'h100;
      put_s2(1, 13'h010);
      chk("t6_inc_inv", w(1), 32'h200);
      put_s2(2, 13'h010);
      chk("t6_start2", w(2), 32'h100);
      put_s2(2, 13'h500);
      chk("t6_dec_inv", w(2), 32'h200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
